// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared widths, encodings and queue entry type for the fetch stage
package instr_fetch_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [ILEN-1:0] DEF_NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/instr_fetch_queue.sv
// fetch_queue: 2-entry synchronous FIFO of fetched words; flush beats push
module fetch_queue
  import instr_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [1:0]   count
);
  fetch_entry_t mem [2];
  logic rd_ptr, wr_ptr;
  assign head = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) mem[wr_ptr] <= din;
      wr_ptr <= wr_ptr ^ push;
      rd_ptr <= rd_ptr ^ pop;
      count  <= count + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC holder issuing 1-cycle-latency imem reads into a 2-entry queue feeding decode
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [ILEN-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect_en,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [ILEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_valid,
  input  logic            instr_ready
);
  logic [XLEN-1:0] pc, inflight_pc, last_pc;
  logic inflight, pop;
  logic [1:0] count;
  logic [2:0] occ;
  fetch_entry_t head, din;
  always_comb begin
    pop         = instr_valid && instr_ready;
    occ         = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
    imem_req    = !rst && !redirect_en && (occ < 3'd2);
    imem_addr   = pc;
    instr_valid = count != 2'd0;
    instr       = instr_valid ? head.instr : NOP_INSTR;
    instr_pc    = instr_valid ? head.pc : last_pc;
    din         = '{instr: imem_rdata, pc: inflight_pc};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
      last_pc     <= RESET_PC;
    end else begin
      pc          <= redirect_en ? {redirect_pc[XLEN-1:2], 2'b00} : imem_req ? pc + 32'd4 : pc;
      inflight    <= imem_req;
      inflight_pc <= pc;
      last_pc     <= pop ? head.pc : last_pc;
    end
  end
  fetch_queue u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight),
    .pop   (pop),
    .flush (redirect_en),
    .din   (din),
    .head  (head),
    .count (count)
  );
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized bench comparing instr_fetch against a queue-based fetch model
module tb_instr_fetch;
  logic clk = 1'b0;
  logic rst, imem_req, redirect_en, instr_valid, instr_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, instr_pc;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] m_pc, m_ipc, m_last;
  logic m_inf, last_req, exp_req, pop;
  logic [31:0] last_addr;
  logic [31:0] q[$];
  always #5 clk = ~clk;
  instr_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
  );
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h0000_0013;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  initial begin
    rst = 1'b1; redirect_en = 1'b0; redirect_pc = '0; instr_ready = 1'b0; imem_rdata = '0;
    m_pc = '0; m_ipc = '0; m_last = '0; m_inf = 1'b0; last_req = 1'b0; last_addr = '0;
    #1;
    for (int c = 0; c < 3000; c++) begin
      rst = (c < 2) || (c == 250) || (c > 300 && $urandom_range(0, 199) == 0);
      instr_ready = (c >= 30 && c <= 34) || (c >= 240 && c <= 250) ? 1'b0 :
                    (c < 60) ? 1'b1 : ($urandom_range(0, 9) < 7);
      redirect_en = 1'b0;
      redirect_pc = $urandom;
      if (c == 60 || c == 100 || c == 101 || c == 150 || c == 200) begin
        redirect_en = 1'b1;
        redirect_pc = c == 60 ? 32'h0000_0050 : c == 100 ? 32'h0000_0100 :
                      c == 101 ? 32'h0000_0200 : c == 150 ? 32'h0000_0083 : 32'hFFFF_FFFC;
      end else if (c > 300 && $urandom_range(0, 7) == 0) begin
        redirect_en = 1'b1;
        redirect_pc = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)) : $urandom;
      end
      imem_rdata = last_req ? mem_word(last_addr) : $urandom;
      @(negedge clk);
      pop = (q.size() != 0) && instr_ready;
      exp_req = !rst && !redirect_en && (q.size() + int'(m_inf) - int'(pop) < 2);
      if (c > 0) begin
        check("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
        check("imem_addr", imem_addr, m_pc);
        check("instr_valid", {31'b0, instr_valid}, {31'b0, q.size() != 0});
        check("instr_pc", instr_pc, q.size() != 0 ? q[0] : m_last);
        check("instr", instr, q.size() != 0 ? mem_word(q[0]) : 32'h0000_0013);
      end
      last_req = imem_req;
      last_addr = imem_addr;
      if (rst) begin
        m_pc = '0; m_ipc = '0; m_last = '0; m_inf = 1'b0;
        q.delete();
      end else begin
        if (pop) m_last = q.pop_front();
        if (redirect_en) q.delete();
        else if (m_inf) q.push_back(m_ipc);
        m_inf = exp_req;
        m_ipc = m_pc;
        m_pc = redirect_en ? {redirect_pc[31:2], 2'b00} : exp_req ? m_pc + 32'd4 : m_pc;
      end
      @(posedge clk);
      #1;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
